// File: rtl/iq_serial_pkg.sv
// Shared definitions for the IQ demap serializer: FSM states, bit-order modes
// and legal parameter limits.
package iq_serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic MODE_BLOCK = 1'b0;
  localparam logic MODE_ALT   = 1'b1;

  localparam int W_MIN   = 1;
  localparam int W_MAX   = 4;
  localparam int DIV_MIN = 1;
  localparam int DIV_MAX = 16;

endpackage

// File: rtl/bit_strobe_gen.sv
// Bit-period divider: counts 0..DIV-1 while enabled; tick marks the last cycle
// of a period, so the following cycle starts a new bit period.
module bit_strobe_gen
  import iq_serial_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk_fs,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < DIV_MIN || DIV > DIV_MAX) begin : g_bad_div
    $fatal(1, "bit_strobe_gen: DIV out of range");
  end

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk_fs or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/iq_demap_serializer.sv
// Serializes I/Q decision bits onto one line, DIV clk_fs cycles per bit, with
// a one-deep pending slot in front of the shift register.
module iq_demap_serializer
  import iq_serial_pkg::*;
#(
  parameter int W   = 2,
  parameter int DIV = 2
) (
  input  logic         clk_fs,
  input  logic         rst,
  input  logic         mode,
  input  logic [W-1:0] sym_i,
  input  logic [W-1:0] sym_q,
  input  logic         sym_valid,
  output logic         sym_ready,
  input  logic         clr_ovr,
  output logic         bit_out,
  output logic         bit_valid,
  output logic         sym_first,
  output logic         overrun
);

  localparam int NB = 2 * W;
  localparam int BW = $clog2(NB);

  if (W < W_MIN || W > W_MAX) begin : g_bad_w
    $fatal(1, "iq_demap_serializer: W out of range");
  end

  // Output order is fixed at accept time so mode only matters when sampled.
  function automatic logic [NB-1:0] order_bits(input logic [W-1:0] i,
                                               input logic [W-1:0] q,
                                               input logic         m);
    logic [NB-1:0] r;
    r = '0;
    if (m == MODE_BLOCK) begin
      r = {i, q};
    end else begin
      for (int unsigned k = 0; k < W; k++) begin
        r[2*k+1] = i[k];
        r[2*k]   = q[k];
      end
    end
    return r;
  endfunction

  state_t        state;
  logic          pend_full;
  logic [NB-1:0] pend_bits;
  logic [NB-1:0] sreg;
  logic [BW-1:0] bcnt;
  logic          tick;
  logic          last_bit;
  logic          accept;
  logic          load;

  bit_strobe_gen #(.DIV(DIV)) u_div (
    .clk_fs (clk_fs),
    .rst    (rst),
    .en     (state == SHIFT),
    .tick   (tick)
  );

  assign sym_ready = ~pend_full;
  assign accept    = sym_valid && !pend_full;
  assign last_bit  = (bcnt == BW'(NB - 1));
  assign load      = pend_full && ((state == IDLE) || (tick && last_bit));

  always_ff @(posedge clk_fs or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pend_full <= 1'b0;
      pend_bits <= '0;
      sreg      <= '0;
      bcnt      <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      sym_first <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      sym_first <= 1'b0;

      if (accept) begin
        pend_bits <= order_bits(sym_i, sym_q, mode);
        pend_full <= 1'b1;
      end else if (load) begin
        pend_full <= 1'b0;
      end

      if (sym_valid && pend_full) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end

      // Loading covers both IDLE start and gapless back-to-back continuation.
      if (load) begin
        state     <= SHIFT;
        bit_out   <= pend_bits[NB-1];
        sreg      <= pend_bits << 1;
        bcnt      <= '0;
        bit_valid <= 1'b1;
        sym_first <= 1'b1;
      end else if (state == SHIFT && tick) begin
        if (last_bit) begin
          state <= IDLE;
        end else begin
          bit_out   <= sreg[NB-1];
          sreg      <= sreg << 1;
          bcnt      <= bcnt + 1'b1;
          bit_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_iq_demap_serializer.sv
// Directed bench for iq_demap_serializer: W=2/DIV=2 table vectors plus
// back-to-back, overrun, mid-symbol reset and a W=4/DIV=1 instance.
module tb_iq_demap_serializer;

  logic clk_fs = 1'b0;
  always #5 clk_fs = ~clk_fs;

  logic rst = 1'b1;

  logic       mode, sym_valid, clr_ovr;
  logic [1:0] sym_i, sym_q;
  logic       sym_ready, bit_out, bit_valid, sym_first, overrun;

  logic       mode4, sym_valid4;
  logic [3:0] sym_i4, sym_q4;
  logic       sym_ready4, bit_out4, bit_valid4, sym_first4, overrun4;

  iq_demap_serializer #(.W(2), .DIV(2)) dut (
    .clk_fs    (clk_fs),
    .rst       (rst),
    .mode      (mode),
    .sym_i     (sym_i),
    .sym_q     (sym_q),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .clr_ovr   (clr_ovr),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .sym_first (sym_first),
    .overrun   (overrun)
  );

  iq_demap_serializer #(.W(4), .DIV(1)) dut4 (
    .clk_fs    (clk_fs),
    .rst       (rst),
    .mode      (mode4),
    .sym_i     (sym_i4),
    .sym_q     (sym_q4),
    .sym_valid (sym_valid4),
    .sym_ready (sym_ready4),
    .clr_ovr   (1'b0),
    .bit_out   (bit_out4),
    .bit_valid (bit_valid4),
    .sym_first (sym_first4),
    .overrun   (overrun4)
  );

  typedef struct {
    logic       mode;
    logic [1:0] i;
    logic [1:0] q;
    logic [3:0] exp_bits;  // first transmitted bit in [3]
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int rel, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (rel cycle %0d): got %0h expected %0h", nm, rel, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_fs);
    #1;
  endtask

  // Accept one symbol in the current cycle, flip mode afterwards, then check
  // strobe timing, bit values, hold behaviour and sym_first cycle by cycle.
  task automatic run_vec(input vec_t v);
    int k;
    mode = v.mode; sym_i = v.i; sym_q = v.q; sym_valid = 1'b1;
    chk("ready_at_accept", 0, sym_ready, 1);
    step();
    sym_valid = 1'b0; mode = ~v.mode; sym_i = ~v.i; sym_q = ~v.q;
    for (int rel = 1; rel <= 12; rel++) begin
      chk("bit_valid", rel, bit_valid, (rel >= 2 && rel <= 9 && rel % 2 == 0) ? 1 : 0);
      chk("sym_first", rel, sym_first, (rel == 2) ? 1 : 0);
      if (rel >= 2 && rel <= 9) begin
        k = (rel - 2) / 2;
        chk("bit_out", rel, bit_out, v.exp_bits[3-k]);
      end
      step();
    end
  endtask

  vec_t vecs[6];
  logic [7:0] exp8;

  initial begin
    mode = 1'b0; sym_i = '0; sym_q = '0; sym_valid = 1'b0; clr_ovr = 1'b0;
    mode4 = 1'b0; sym_i4 = '0; sym_q4 = '0; sym_valid4 = 1'b0;

    vecs[0] = '{mode: 1'b0, i: 2'b11, q: 2'b00, exp_bits: 4'b1100};
    vecs[1] = '{mode: 1'b1, i: 2'b11, q: 2'b00, exp_bits: 4'b1010};
    vecs[2] = '{mode: 1'b0, i: 2'b10, q: 2'b01, exp_bits: 4'b1001};
    vecs[3] = '{mode: 1'b1, i: 2'b10, q: 2'b01, exp_bits: 4'b1001};
    vecs[4] = '{mode: 1'b0, i: 2'b01, q: 2'b10, exp_bits: 4'b0110};
    vecs[5] = '{mode: 1'b1, i: 2'b01, q: 2'b10, exp_bits: 4'b0110};

    step(); step();
    chk("rst_bit_out", 0, bit_out, 0);
    chk("rst_bit_valid", 0, bit_valid, 0);
    chk("rst_sym_first", 0, sym_first, 0);
    chk("rst_overrun", 0, overrun, 0);
    chk("rst_sym_ready", 0, sym_ready, 1);
    rst = 1'b0;
    step();

    foreach (vecs[n]) run_vec(vecs[n]);

    // Back-to-back: A accepted at rel 0, B at rel 3, C offered at rel 5 while full.
    exp8 = 8'b1100_1001;
    mode = 1'b0; sym_i = 2'b11; sym_q = 2'b00; sym_valid = 1'b1;
    step();
    for (int rel = 1; rel <= 20; rel++) begin
      sym_valid = 1'b0; clr_ovr = 1'b0;
      if (rel == 3) begin sym_i = 2'b10; sym_q = 2'b01; sym_valid = 1'b1; end
      if (rel == 5) begin sym_i = 2'b01; sym_q = 2'b10; sym_valid = 1'b1; end
      if (rel == 18) clr_ovr = 1'b1;
      chk("b2b_bit_valid", rel, bit_valid,
          (rel >= 2 && rel <= 16 && rel % 2 == 0) ? 1 : 0);
      chk("b2b_sym_first", rel, sym_first, (rel == 2 || rel == 10) ? 1 : 0);
      if (rel >= 2 && rel <= 17) chk("b2b_bit_out", rel, bit_out, exp8[7-(rel-2)/2]);
      if (rel == 1) chk("ready_while_full", rel, sym_ready, 0);
      if (rel == 2) chk("ready_after_load", rel, sym_ready, 1);
      if (rel == 5) chk("ready_on_drop", rel, sym_ready, 0);
      if (rel == 5) chk("overrun_before_drop", rel, overrun, 0);
      if (rel >= 6 && rel <= 18) chk("overrun_sticky", rel, overrun, 1);
      if (rel == 19) chk("overrun_cleared", rel, overrun, 0);
      step();
    end

    // Reset in the middle of bit 2 with B already pending; both are abandoned.
    mode = 1'b0; sym_i = 2'b11; sym_q = 2'b00; sym_valid = 1'b1;
    step();
    for (int rel = 1; rel < 6; rel++) begin
      sym_valid = (rel == 3);
      sym_i = 2'b10; sym_q = 2'b01;
      step();
    end
    sym_valid = 1'b0;
    chk("pre_rst_bit_valid", 6, bit_valid, 1);
    chk("pre_rst_bit_out", 6, bit_out, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_bit_out", 6, bit_out, 0);
    chk("mid_rst_bit_valid", 6, bit_valid, 0);
    chk("mid_rst_sym_first", 6, sym_first, 0);
    chk("mid_rst_overrun", 6, overrun, 0);
    chk("mid_rst_sym_ready", 6, sym_ready, 1);
    #2 rst = 1'b0;
    for (int rel = 7; rel <= 16; rel++) begin
      step();
      chk("post_rst_no_strobe", rel, bit_valid, 0);
      chk("post_rst_ready", rel, sym_ready, 1);
    end
    run_vec(vecs[2]);

    // W=4, DIV=1, alternating order: a strobe on every SHIFT cycle.
    exp8 = 8'b1001_1100;
    mode4 = 1'b1; sym_i4 = 4'b1010; sym_q4 = 4'b0110; sym_valid4 = 1'b1;
    step();
    sym_valid4 = 1'b0; mode4 = 1'b0;
    for (int rel = 1; rel <= 11; rel++) begin
      chk("w4_bit_valid", rel, bit_valid4, (rel >= 2 && rel <= 9) ? 1 : 0);
      chk("w4_sym_first", rel, sym_first4, (rel == 2) ? 1 : 0);
      if (rel >= 2 && rel <= 9) chk("w4_bit_out", rel, bit_out4, exp8[7-(rel-2)]);
      step();
    end
    chk("w4_overrun", 0, overrun4, 0);
    chk("w4_ready", 0, sym_ready4, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/iq_demap_serializer.md
IQ_DEMAP_SERIALIZER -- requirements
Module: iq_demap_serializer

Interface
REQ-001 The block SHALL have parameter W, default 2: bits per axis (I and Q each); legal range 1..4.
REQ-002 The block SHALL have parameter DIV, default 2: clk_fs cycles per output bit; legal range 1..16.
REQ-003 The block SHALL have port clk_fs, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port mode, input, 1 bit: bit order; 0 = I block then Q block, 1 = I/Q alternating per bit.
REQ-006 The block SHALL have port sym_i, input, W bits: I-axis decision bits.
REQ-007 The block SHALL have port sym_q, input, W bits: Q-axis decision bits.
REQ-008 The block SHALL have port sym_valid, input, 1 bit: symbol present this cycle.
REQ-009 The block SHALL have port sym_ready, output, 1 bit: the pending slot is empty and a symbol can be accepted.
REQ-010 The block SHALL have port clr_ovr, input, 1 bit: synchronous clear of overrun.
REQ-011 The block SHALL have port bit_out, output, 1 bit: the current serial bit, held for DIV cycles.
REQ-012 The block SHALL have port bit_valid, output, 1 bit: one-cycle strobe on the first cycle of each bit period.
REQ-013 The block SHALL have port sym_first, output, 1 bit: coincides with bit_valid for the first bit of each symbol.
REQ-014 The block SHALL have port overrun, output, 1 bit: sticky flag indicating that a symbol was dropped.

Function
REQ-015 Accept: sym_valid and sym_ready in the same cycle SHALL latch sym_i, sym_q and mode into a one-deep pending slot; mode is sampled only at accept.
REQ-016 sym_ready SHALL be high exactly when the pending slot is empty.
REQ-017 Drop: sym_valid with sym_ready low SHALL discard the symbol and set overrun; overrun holds until clr_ovr or rst, and a set in the same cycle as clr_ovr wins.
REQ-018 State machine SHALL have states IDLE and SHIFT; IDLE->SHIFT when the pending slot is full, moving pending into the shift register and freeing the slot in the same cycle.
REQ-019 Latency: a symbol accepted in cycle N while in IDLE with the slot empty SHALL give its first bit_valid in cycle N+2 (N+1 load, N+2 first bit).
REQ-020 Bit periods SHALL each be exactly DIV cycles; a symbol occupies 2*W*DIV cycles; a bit counter runs 0..2W-1, and a divider counter runs 0..DIV-1 and wraps.
REQ-021 Mode 0 order SHALL be I[W-1]..I[0], then Q[W-1]..Q[0]; mode 1 order SHALL be I[W-1], Q[W-1], I[W-2], Q[W-2], ..., I[0], Q[0].
REQ-022 Back-to-back: if the slot is full at the last cycle of the last bit period, the next symbol's first bit_valid SHALL follow in the next cycle with no gap; otherwise SHIFT->IDLE.
REQ-023 Simultaneous slot free and accept in the same cycle: sym_ready reflects the registered slot state, so the accept SHALL be refused that cycle (overrun set if sym_valid); no combinational ready path.
REQ-024 In IDLE: bit_out SHALL hold its last value, and bit_valid and sym_first SHALL be 0.
REQ-025 DIV=1: bit_valid SHALL be high on every SHIFT cycle.

Reset
REQ-026 rst SHALL asynchronously force: state IDLE, slot empty, counters 0, bit_out 0, bit_valid 0, sym_first 0, overrun 0, sym_ready 1.
REQ-027 rst asserted mid-symbol SHALL abandon the symbol and the pending slot without emitting further strobes; operation resumes from the first cycle after deassertion.

Structure
REQ-028 Package iq_serial_pkg SHALL hold the state enumeration, the MODE_BLOCK (0) and MODE_ALT (1) constants, and the W/DIV limits.
REQ-029 The divider SHALL be a sub-module, bit_strobe_gen: a DIV counter with enable and a period-start strobe output.
REQ-030 Parameter ranges SHALL be checked at elaboration, and out-of-range values SHALL be a fatal error.

Verification
REQ-031 W=2, DIV=2, mode 0, I=11, Q=00, accept at cycle 0 -> bits 1,1,0,0 with strobes at cycles 2,4,6,8, and sym_first at 2.
REQ-032 Same symbol with mode 1 -> bits 1,0,1,0; with I=10, Q=01 -> mode 0 gives 1,0,0,1 and mode 1 gives 1,0,0,1.
REQ-033 Two symbols with the second accepted while the first shifts -> strobes continuous every 2 cycles, eight total, sym_first at strobes 1 and 5.
REQ-034 Third symbol offered while the slot is full -> sym_ready 0, overrun 1 next cycle, dropped bits absent from the output; clr_ovr -> overrun 0.
REQ-035 rst pulse at bit 2 of a symbol -> all outputs 0 immediately, sym_ready 1, and no strobe until a new accept.
REQ-036 W=4, DIV=1, mode 1, I=1010, Q=0110 -> bits 1,0,0,1,1,1,0,0 on 8 consecutive strobes.
